// File: rtl/parity_check_if.sv
// Bus bundle for the parity checker.
// Master (producer / bench) drives: init, data_in, par_in.
// Slave (parity_check) drives:     busy, done, err, ones.
// WIDTH must match the WIDTH of the parity_check instance on the slave side.
interface parity_check_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             init;
  logic [WIDTH-1:0] data_in;
  logic             par_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] ones;

  modport master (
    output init, data_in, par_in,
    input  busy, done, err, ones
  );

  modport slave (
    input  init, data_in, par_in,
    output busy, done, err, ones
  );
endinterface

// File: rtl/parity_check.sv
// parity_check: receive-side parity checker.
// Captures a WIDTH-bit word and its received parity bit on an init pulse,
// counts the ones serially (one bit per clock), recomputes parity and flags
// a mismatch with a one-cycle done pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bus       parity_check_if.slave
//               init    start request (only honoured in IDLE)
//               data_in word to check, captured on the accepting edge
//               par_in  received parity, captured with data_in
//               busy    high in SHIFT, CHECK and DONE
//               done    one-cycle pulse, err/ones valid while high
//               err     received parity differs from recomputed parity
//               ones    number of 1 bits in the captured word
//
// Parameters:
//   WIDTH    data width (>= 2)
//   PAR_ODD  0 = even parity (par = XOR of bits), 1 = odd parity (XNOR)
//
// Build option:
//   PARITY_CHECK_STICKY_EN  when defined, err accumulates mismatches until
//                           reset instead of reflecting only the last frame.
//
// state   | meaning
// --------+------------------------------------------------
// S_IDLE  | waiting for init; outputs err/ones hold
// S_SHIFT | WIDTH cycles of add-LSB / shift-right
// S_CHECK | compare recomputed parity, update err and ones
// S_DONE  | done pulse, back to IDLE on next edge
module parity_check #(
  parameter int WIDTH   = 8,
  parameter bit PAR_ODD = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  parity_check_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_q;
  logic             par_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] ones_q;
  logic             mismatch;

  // Parity of the word is the LSB of its ones count.
  assign mismatch = (acc_q[0] ^ PAR_ODD) != par_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.init) state_nxt = S_SHIFT;
      // Counter still holds the pre-increment value, so WIDTH-1 marks the last shift.
      S_SHIFT: if (bit_cnt_q == CNT_W'(WIDTH - 1)) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      S_SHIFT: bus.busy = 1'b1;
      S_CHECK: bus.busy = 1'b1;
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.err  = err_q;
  assign bus.ones = ones_q;

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      par_q     <= 1'b0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
      ones_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.init) begin
            shift_q   <= bus.data_in;
            par_q     <= bus.par_in;
            acc_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        S_SHIFT: begin
          acc_q     <= acc_q + CNT_W'(shift_q[0]);
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
        S_CHECK: begin
`ifdef PARITY_CHECK_STICKY_EN
          err_q  <= err_q | mismatch;
`else
          err_q  <= mismatch;
`endif
          ones_q <= acc_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_check.sv
// Self-checking bench for parity_check: an even-parity and an odd-parity
// instance share all stimulus. A frame-level model (countones, cycle budget
// per frame) predicts busy/done/err/ones every cycle; directed frames pin
// the model with hand-computed values.
module tb_parity_check;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             init = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             par_in = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  parity_check_if #(.WIDTH(WIDTH)) if_e ();
  parity_check_if #(.WIDTH(WIDTH)) if_o ();

  assign if_e.init    = init;
  assign if_e.data_in = data_in;
  assign if_e.par_in  = par_in;
  assign if_o.init    = init;
  assign if_o.data_in = data_in;
  assign if_o.par_in  = par_in;

  parity_check #(.WIDTH(WIDTH), .PAR_ODD(1'b0)) u_even (.clk(clk), .rst(rst), .bus(if_e.slave));
  parity_check #(.WIDTH(WIDTH), .PAR_ODD(1'b1)) u_odd  (.clk(clk), .rst(rst), .bus(if_o.slave));

  always #5 clk = ~clk;

  // Frame-level model: a frame occupies WIDTH+2 busy cycles; results appear
  // on the last of them (the done cycle).
  int               m_left = 0;
  logic [WIDTH-1:0] f_data;
  logic             f_par;
  int               m_ones = 0;
  bit               m_err_e = 0;
  bit               m_err_o = 0;
  int               n1;
  bit               xor_par;
  bit               mis_e, mis_o;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_ones = 0; m_err_e = 0; m_err_o = 0;
    end else if (m_left == 0) begin
      if (init) begin
        f_data = data_in;
        f_par  = par_in;
        m_left = WIDTH + 2;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        n1      = $countones(f_data);
        xor_par = (n1 % 2) == 1;
        mis_e   = f_par != xor_par;
        mis_o   = f_par != !xor_par;
        m_ones  = n1;
        m_err_e = STICKY ? (m_err_e | mis_e) : mis_e;
        m_err_o = STICKY ? (m_err_o | mis_o) : mis_o;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_e", int'(if_e.busy), int'(m_left != 0));
      check("done_e", int'(if_e.done), int'(m_left == 1));
      check("err_e",  int'(if_e.err),  int'(m_err_e));
      check("ones_e", int'(if_e.ones), m_ones);
      check("busy_o", int'(if_o.busy), int'(m_left != 0));
      check("done_o", int'(if_o.done), int'(m_left == 1));
      check("err_o",  int'(if_o.err),  int'(m_err_o));
      check("ones_o", int'(if_o.ones), m_ones);
    end
  end

  // Entered and left at a negedge with the DUT idle.
  task automatic run_frame(input logic [WIDTH-1:0] d, input logic p, input bit mid_init,
                           output int lat, output int bcnt, output int dcnt);
    init = 1'b1; data_in = d; par_in = p;
    @(negedge clk);
    init = 1'b0; data_in = WIDTH'($urandom); par_in = 1'($urandom);
    lat = -1; bcnt = 0; dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (mid_init && i == 3) begin
        init = 1'b1; data_in = '1;
      end else begin
        init = 1'b0;
      end
      if (if_e.busy) bcnt++;
      if (if_e.done) begin
        dcnt++;
        if (lat < 0) lat = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat, bcnt, dcnt;

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(if_e.busy), 0);
    check("reset_ones", int'(if_e.ones), 0);

    // 0x4F has 5 ones: even parity 1, odd parity 0.
    run_frame(8'b0100_1111, 1'b1, 1'b0, lat, bcnt, dcnt);
    check("lat_4f", lat, 9);
    check("busy_cycles_4f", bcnt, 10);
    check("done_pulses_4f", dcnt, 1);
    check("ones_4f", int'(if_e.ones), 5);
    check("err_e_4f_p1", int'(if_e.err), 0);
    check("err_o_4f_p1", int'(if_o.err), 1);

    do_reset();
    run_frame(8'b0100_1111, 1'b0, 1'b0, lat, bcnt, dcnt);
    check("err_e_4f_p0", int'(if_e.err), 1);
    check("err_o_4f_p0", int'(if_o.err), 0);

    do_reset();
    run_frame(8'hFF, 1'b0, 1'b0, lat, bcnt, dcnt);
    check("ones_ff", int'(if_e.ones), 8);
    check("err_e_ff", int'(if_e.err), 0);
    check("err_o_ff", int'(if_o.err), 1);

    do_reset();
    run_frame(8'h00, 1'b0, 1'b0, lat, bcnt, dcnt);
    check("ones_00", int'(if_e.ones), 0);
    check("err_e_00", int'(if_e.err), 0);

    // Second init during SHIFT with new data must be ignored.
    do_reset();
    run_frame(8'hA5, 1'b0, 1'b1, lat, bcnt, dcnt);
    check("done_pulses_a5", dcnt, 1);
    check("ones_a5", int'(if_e.ones), 4);
    check("err_e_a5", int'(if_e.err), 0);

    // Reset partway through SHIFT aborts the frame.
    init = 1'b1; data_in = 8'b0100_1111; par_in = 1'b0;
    @(negedge clk);
    init = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (if_e.done) dcnt++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(if_e.busy), 0);
    check("abort_err", int'(if_e.err), 0);
    check("abort_ones", int'(if_e.ones), 0);
    for (int i = 0; i < 12; i++) begin
      if (if_e.done) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);
    run_frame(8'h03, 1'b0, 1'b0, lat, bcnt, dcnt);
    check("ones_03", int'(if_e.ones), 2);
    check("err_e_03", int'(if_e.err), 0);

    // Bad frame then good frame: sticky build keeps err set.
    do_reset();
    run_frame(8'b0100_1111, 1'b0, 1'b0, lat, bcnt, dcnt);
    run_frame(8'h01, 1'b1, 1'b0, lat, bcnt, dcnt);
    check("sticky_err_e", int'(if_e.err), STICKY ? 1 : 0);
    check("sticky_ones", int'(if_e.ones), 1);
    do_reset();
    check("sticky_clear_e", int'(if_e.err), 0);
    check("sticky_clear_o", int'(if_o.err), 0);

    // Held-high init restarts every WIDTH+3 cycles.
    init = 1'b1; data_in = 8'h3C; par_in = 1'b0;
    @(negedge clk);
    dcnt = 0;
    for (int i = 0; i < 33; i++) begin
      if (if_e.done) dcnt++;
      @(negedge clk);
    end
    check("held_init_dones", dcnt, 3);
    init = 1'b0;
    repeat (14) @(negedge clk);

    // Random traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 79) == 0);
      init    = ($urandom_range(0, 2) == 0);
      data_in = WIDTH'($urandom);
      par_in  = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; init = 1'b0;
    repeat (14) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
